// File: rtl/alu_4bit.sv
// alu_4bit
//   Registered 4-bit ALU with eight operations selected by a 3-bit opcode.
//   The result is computed combinationally from the operands, then registered
//   together with a carry/borrow/shift-out flag and a zero flag. Every rising
//   edge loads a new result, so latency is one cycle and throughput is one
//   operation per cycle.
//
// Ports
//   clk     in   1  clock, rising edge
//   rstn    in   1  asynchronous active-low reset
//   OP1     in   4  operand A
//   OP2     in   4  operand B
//   OPCODE  in   3  operation select
//   RESULT  out  4  registered result
//   CARRY   out  1  registered carry / borrow / shift-out
//   ZERO    out  1  registered flag, 1 when RESULT is 0000
module alu_4bit (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] OP1,
   input  logic [3:0] OP2,
   input  logic [2:0] OPCODE,
   output logic [3:0] RESULT,
   output logic       CARRY,
   output logic       ZERO
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } opcode_t;

   logic [3:0] next_result;
   logic       next_carry;
   logic [4:0] sum_ext;
   logic [4:0] diff_ext;

   // Bit 4 of the zero-extended difference is the borrow (set when A < B).
   assign sum_ext  = {1'b0, OP1} + {1'b0, OP2};
   assign diff_ext = {1'b0, OP1} - {1'b0, OP2};

   always_comb begin
      next_result = '0;
      next_carry  = 1'b0;
      case (opcode_t'(OPCODE))
         OP_ADD: {next_carry, next_result} = sum_ext;
         OP_SUB: {next_carry, next_result} = diff_ext;
         OP_AND: next_result = OP1 & OP2;
         OP_OR:  next_result = OP1 | OP2;
         OP_XOR: next_result = OP1 ^ OP2;
         OP_NOT: next_result = ~OP1;
         OP_SHL: begin
            next_result = {OP1[2:0], 1'b0};
            next_carry  = OP1[3];
         end
         OP_SHR: begin
            next_result = {1'b0, OP1[3:1]};
            next_carry  = OP1[0];
         end
         default: begin
            next_result = '0;
            next_carry  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         RESULT <= '0;
         CARRY  <= 1'b0;
         ZERO   <= 1'b1;
      end else begin
         RESULT <= next_result;
         CARRY  <= next_carry;
         ZERO   <= (next_result == 4'b0000);
      end
   end

endmodule

// File: tb/tb_alu_4bit.sv
module tb_alu_4bit;

   logic       clk;
   logic       rstn;
   logic [3:0] OP1;
   logic [3:0] OP2;
   logic [2:0] OPCODE;
   logic [3:0] RESULT;
   logic       CARRY;
   logic       ZERO;

   int n_cmp;
   int n_err;

   alu_4bit dut (
      .clk    (clk),
      .rstn   (rstn),
      .OP1    (OP1),
      .OP2    (OP2),
      .OPCODE (OPCODE),
      .RESULT (RESULT),
      .CARRY  (CARRY),
      .ZERO   (ZERO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one operation at the falling edge, then step past the next rising
   // edge; consecutive calls therefore occupy consecutive clock edges.
   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] opc);
      @(negedge clk);
      OP1    = a;
      OP2    = b;
      OPCODE = opc;
      @(posedge clk);
      #1;
   endtask

   // Observed vector is {CARRY, ZERO, RESULT}.
   task automatic test_reset;
      rstn   = 1'b1;
      OP1    = 4'b0000;
      OP2    = 4'b0000;
      OPCODE = 3'b000;
      #2 rstn = 1'b0;
      #1;
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL reset_initial got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
      @(negedge clk);
      rstn = 1'b1;

      apply(4'b0010, 4'b0011, 3'b000);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_0101) begin
         n_err++;
         $display("FAIL prior_add got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_0101);
      end

      // Mid-cycle assertion must clear outputs without a clock edge.
      #2 rstn = 1'b0;
      #1;
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL reset_async got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end

      // Inputs applied while in reset are ignored across an edge.
      @(negedge clk);
      OP1    = 4'b1111;
      OP2    = 4'b1111;
      OPCODE = 3'b000;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL reset_hold got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL reset_release got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
   endtask

   task automatic test_add;
      // First edge after release loads normally.
      apply(4'b1111, 4'b0001, 3'b000);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b11_0000) begin
         n_err++;
         $display("FAIL add_wrap got %b want %b", {CARRY, ZERO, RESULT}, 6'b11_0000);
      end
      apply(4'b0011, 4'b0100, 3'b000);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_0111) begin
         n_err++;
         $display("FAIL add_plain got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_0111);
      end
      apply(4'b1001, 4'b1000, 3'b000);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b10_0001) begin
         n_err++;
         $display("FAIL add_carry got %b want %b", {CARRY, ZERO, RESULT}, 6'b10_0001);
      end
   endtask

   task automatic test_sub;
      apply(4'b0010, 4'b0101, 3'b001);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b10_1101) begin
         n_err++;
         $display("FAIL sub_borrow got %b want %b", {CARRY, ZERO, RESULT}, 6'b10_1101);
      end
      apply(4'b0101, 4'b0101, 3'b001);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL sub_equal got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
      apply(4'b0000, 4'b0001, 3'b001);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b10_1111) begin
         n_err++;
         $display("FAIL sub_wrap got %b want %b", {CARRY, ZERO, RESULT}, 6'b10_1111);
      end
      apply(4'b1001, 4'b0011, 3'b001);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_0110) begin
         n_err++;
         $display("FAIL sub_plain got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_0110);
      end
   endtask

   task automatic test_logic;
      apply(4'b1100, 4'b1010, 3'b010);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_1000) begin
         n_err++;
         $display("FAIL and got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_1000);
      end
      apply(4'b1100, 4'b1010, 3'b011);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_1110) begin
         n_err++;
         $display("FAIL or got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_1110);
      end
      apply(4'b1100, 4'b1010, 3'b100);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_0110) begin
         n_err++;
         $display("FAIL xor got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_0110);
      end
      apply(4'b1100, 4'b1010, 3'b101);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_0011) begin
         n_err++;
         $display("FAIL not got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_0011);
      end
      apply(4'b0101, 4'b1010, 3'b010);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL and_zero got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
   endtask

   task automatic test_shr_zero;
      apply(4'b0000, 4'b1111, 3'b111);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b01_0000) begin
         n_err++;
         $display("FAIL shr_zero got %b want %b", {CARRY, ZERO, RESULT}, 6'b01_0000);
      end
   endtask

   task automatic test_back_to_back;
      apply(4'b1001, 4'b0000, 3'b110);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b10_0010) begin
         n_err++;
         $display("FAIL shl got %b want %b", {CARRY, ZERO, RESULT}, 6'b10_0010);
      end
      apply(4'b1001, 4'b0000, 3'b111);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b10_0100) begin
         n_err++;
         $display("FAIL shr got %b want %b", {CARRY, ZERO, RESULT}, 6'b10_0100);
      end
      apply(4'b0110, 4'b0011, 3'b000);
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_1001) begin
         n_err++;
         $display("FAIL b2b_add got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_1001);
      end
      // Changing inputs between edges must not disturb registered outputs.
      OP1    = 4'b1111;
      OP2    = 4'b0001;
      OPCODE = 3'b000;
      #2;
      n_cmp++;
      if ({CARRY, ZERO, RESULT} !== 6'b00_1001) begin
         n_err++;
         $display("FAIL no_comb_path got %b want %b", {CARRY, ZERO, RESULT}, 6'b00_1001);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_shr_zero();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
